// File: rtl/pp_ctrl_pkg.sv
// State types shared by the ping-pong stream controller.
package pp_ctrl_pkg;

  typedef enum logic {FILL = 1'b0, FULL = 1'b1} wr_state_e;
  typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} rd_state_e;

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry first-word-fall-through FIFO with occupancy; entry0 is always the head.
module skid_fifo2 #(
  parameter int WIDTH = 65
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       occ
);

  logic [WIDTH-1:0] entry0;
  logic [WIDTH-1:0] entry1;
  logic [1:0]       cnt;

  assign dout = entry0;
  assign occ  = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  // Data entries carry no reset; occupancy alone says what is meaningful.
  always_ff @(posedge clk) begin
    if (pop) begin
      entry0 <= entry1;
      if (push && cnt == 2'd1) entry0 <= din;
      if (push && cnt == 2'd2) entry1 <= din;
    end else if (push) begin
      if (cnt == 2'd0) entry0 <= din;
      else             entry1 <= din;
    end
  end

endmodule

// File: rtl/ping_pong_stream_ctrl.sv
// Write/read sequencer around a ping-pong buffer: fills one bank from the input
// stream while draining the other bank through a 2-entry skid FIFO.
module ping_pong_stream_ctrl
  import pp_ctrl_pkg::*;
#(
  parameter int BIT_LENGTH = 64,
  parameter int DEPTH      = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  input  logic [BIT_LENGTH-1:0]    s_data,
  input  logic                     s_last,
  output logic                     s_ready,
  output logic                     m_valid,
  output logic [BIT_LENGTH-1:0]    m_data,
  output logic                     m_last,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH)-1:0] pp_addr1,
  output logic [BIT_LENGTH-1:0]    pp_din1,
  output logic                     pp_we1,
  output logic [$clog2(DEPTH)-1:0] pp_addr2,
  input  logic [BIT_LENGTH-1:0]    pp_dout2,
  output logic                     pp_we2,
  output logic [BIT_LENGTH-1:0]    pp_din2,
  output logic                     pp_ping_pong
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);

  wr_state_e wr_state;
  rd_state_e rd_state;

  logic [CW-1:0]     wr_cnt;
  logic [CW-1:0]     rd_cnt;
  logic [CW-1:0]     fill_len;
  logic [CW-1:0]     drain_len;
  logic              ping_pong;
  logic              rd_vld_p1;
  logic              rd_last_p1;
  logic [1:0]        occ;
  logic [BIT_LENGTH:0] head;
  logic              accept;
  logic              swap;
  logic              pop;
  logic              issue;
  logic              issue_last;

  assign s_ready  = (wr_state == FILL);
  assign accept   = s_valid && s_ready;
  assign pp_we1   = accept;
  assign pp_addr1 = wr_cnt[AW-1:0];
  assign pp_din1  = s_data;
  assign pp_we2   = 1'b0;
  assign pp_din2  = '0;

  assign pp_addr2     = rd_cnt[AW-1:0];
  assign pp_ping_pong = ping_pong;

  assign swap = (wr_state == FULL) && (rd_state == IDLE);
  assign pop  = m_valid && m_ready;

  // Credit counts the word leaving this cycle so a full-rate drain never bubbles.
  assign issue = (rd_state == DRAIN) && (rd_cnt < drain_len) &&
                 (({1'b0, occ} + {2'b00, rd_vld_p1} - {2'b00, pop}) < 3'd2);
  assign issue_last = (rd_cnt == drain_len - ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state   <= FILL;
      rd_state   <= IDLE;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      fill_len   <= '0;
      drain_len  <= '0;
      ping_pong  <= 1'b0;
      rd_vld_p1  <= 1'b0;
      rd_last_p1 <= 1'b0;
    end else begin
      rd_vld_p1  <= issue;
      rd_last_p1 <= issue && issue_last;
      if (swap) begin
        ping_pong <= ~ping_pong;
        drain_len <= fill_len;
        wr_cnt    <= '0;
        rd_cnt    <= '0;
        wr_state  <= FILL;
        rd_state  <= DRAIN;
      end else begin
        if (accept) begin
          wr_cnt <= wr_cnt + ONE;
          if (wr_cnt == LAST_IDX || s_last) begin
            wr_state <= FULL;
            fill_len <= wr_cnt + ONE;
          end
        end
        if (issue) rd_cnt <= rd_cnt + ONE;
        // Only go idle once nothing is in flight: the port-2 mux follows ping_pong.
        if (rd_state == DRAIN && rd_cnt == drain_len && !rd_vld_p1) rd_state <= IDLE;
      end
    end
  end

  // Stage p1 -> FIFO: buffer read data returns one cycle after the address.
  skid_fifo2 #(
    .WIDTH(BIT_LENGTH + 1)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (rd_vld_p1),
    .din  ({rd_last_p1, pp_dout2}),
    .pop  (pop),
    .dout (head),
    .occ  (occ)
  );

  assign m_valid = (occ != 2'd0);
  assign m_data  = head[BIT_LENGTH-1:0];
  assign m_last  = m_valid && head[BIT_LENGTH];

endmodule

// File: tb/tb_ping_pong_stream_ctrl.sv
// Bench for ping_pong_stream_ctrl with a behavioural ping-pong buffer and a
// frame-level reference model of the expected output stream.
module tb_ping_pong_stream_ctrl;

  localparam int BL    = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic [BL-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic          s_ready;
  logic          m_valid;
  logic [BL-1:0] m_data;
  logic          m_last;
  logic          m_ready = 1'b0;
  logic [AW-1:0] pp_addr1;
  logic [BL-1:0] pp_din1;
  logic          pp_we1;
  logic [AW-1:0] pp_addr2;
  logic [BL-1:0] pp_dout2;
  logic          pp_we2;
  logic [BL-1:0] pp_din2;
  logic          pp_ping_pong;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ping_pong_stream_ctrl #(.BIT_LENGTH(BL), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
    .pp_addr1(pp_addr1), .pp_din1(pp_din1), .pp_we1(pp_we1),
    .pp_addr2(pp_addr2), .pp_dout2(pp_dout2), .pp_we2(pp_we2), .pp_din2(pp_din2),
    .pp_ping_pong(pp_ping_pong)
  );

  // Ping-pong buffer: port 1 writes bank ping_pong, port 2 reads the other bank,
  // with the bank mux after the read registers.
  logic [BL-1:0] bank_mem [2][DEPTH];
  logic [BL-1:0] rd0, rd1;
  always @(posedge clk) begin
    if (pp_we1) bank_mem[pp_ping_pong][pp_addr1] <= pp_din1;
    rd0 <= bank_mem[0][pp_addr2];
    rd1 <= bank_mem[1][pp_addr2];
  end
  assign pp_dout2 = pp_ping_pong ? rd0 : rd1;

  // Reference model and observers, cleared while reset is held.
  logic [BL:0] exp_q [$];
  logic [BL:0] got_q [$];
  int          frames_q [$];
  int          frame_words, swaps, cyc, first_swap, first_mv;
  int          we_viol, swap_viol, drained_before;
  logic        prev_pp, lst;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete(); got_q.delete(); frames_q.delete();
      frame_words = 0; swaps = 0; cyc = 0; first_swap = -1; first_mv = -1;
      we_viol = 0; swap_viol = 0; prev_pp = 1'b0;
    end else begin
      cyc++;
      if (pp_ping_pong !== prev_pp) begin
        swaps++;
        if (first_swap < 0) first_swap = cyc;
        drained_before = 0;
        for (int k = 0; k < swaps - 1 && k < frames_q.size(); k++) drained_before += frames_q[k];
        if (got_q.size() + 2 < drained_before) swap_viol++;
        if (frames_q.size() < swaps) swap_viol++;
      end
      prev_pp = pp_ping_pong;
      if (m_valid === 1'b1 && first_mv < 0) first_mv = cyc;
      if (pp_we1 === 1'b1 && s_ready !== 1'b1) we_viol++;
      if (s_valid && s_ready) begin
        lst = s_last || (frame_words == DEPTH - 1);
        exp_q.push_back({lst, s_data});
        if (lst) begin frames_q.push_back(frame_words + 1); frame_words = 0; end
        else frame_words++;
      end
      if (m_valid && m_ready) got_q.push_back({m_last, m_data});
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0; m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic send_word(input logic [BL-1:0] d, input logic l);
    logic ok;
    ok = 1'b0;
    s_valid = 1'b1; s_data = d; s_last = l;
    for (int t = 0; t < 1000 && !ok; t++) begin
      @(negedge clk);
      if (s_ready === 1'b1) begin @(posedge clk); #1; ok = 1'b1; end
    end
    s_valid = 1'b0; s_last = 1'b0;
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL send_timeout: word %0h accepted=%0b, required 1", d, ok); end
  endtask

  task automatic test_reset();
    logic [10:0] obs;
    rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0; m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    obs = {s_ready, m_valid, m_last, pp_we1, pp_we2, pp_ping_pong, pp_addr1, pp_addr2, |pp_din2};
    n_checks++;
    if (obs !== 11'b100_0000_0000) begin n_fail++; $display("FAIL reset_held: got %b, required %b", obs, 11'b100_0000_0000); end
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    obs = {s_ready, m_valid, m_last, pp_we1, pp_we2, pp_ping_pong, pp_addr1, pp_addr2, |pp_din2};
    n_checks++;
    if (obs !== 11'b100_0000_0000) begin n_fail++; $display("FAIL reset_idle: got %b, required %b", obs, 11'b100_0000_0000); end
  endtask

  task automatic test_steady();
    logic [BL:0] obs, expv;
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 12; i++) send_word(BL'(i), 1'b0);
    for (int t = 0; t < 500 && got_q.size() < 12; t++) @(posedge clk);
    n_checks++;
    if (got_q.size() !== 12) begin n_fail++; $display("FAIL steady_count: got %0d, required 12", got_q.size()); end
    for (int i = 0; i < 12; i++) begin
      obs = (i < got_q.size()) ? got_q[i] : 'x;
      expv = {1'(i % 4 == 3), BL'(i)};
      n_checks++;
      if (obs !== expv) begin n_fail++; $display("FAIL steady_word%0d: got %h, required %h", i, obs, expv); end
    end
    n_checks++;
    if (swaps !== 3) begin n_fail++; $display("FAIL steady_swaps: got %0d, required 3", swaps); end
    n_checks++;
    if (first_mv - first_swap !== 2) begin n_fail++; $display("FAIL first_mvalid_latency: got %0d, required 2", first_mv - first_swap); end
  endtask

  task automatic test_early_close();
    logic [BL:0] expv [6];
    logic [BL:0] obs;
    expv = '{9'h0A1, 9'h1B2, 9'h010, 9'h011, 9'h012, 9'h113};
    do_reset();
    m_ready = 1'b1;
    send_word(8'hA1, 1'b0);
    send_word(8'hB2, 1'b1);
    for (int i = 0; i < 4; i++) send_word(8'h10 + BL'(i), 1'b0);
    for (int t = 0; t < 500 && got_q.size() < 6; t++) @(posedge clk);
    n_checks++;
    if (got_q.size() !== 6) begin n_fail++; $display("FAIL early_count: got %0d, required 6", got_q.size()); end
    for (int i = 0; i < 6; i++) begin
      obs = (i < got_q.size()) ? got_q[i] : 'x;
      n_checks++;
      if (obs !== expv[i]) begin n_fail++; $display("FAIL early_word%0d: got %h, required %h", i, obs, expv[i]); end
    end
  endtask

  task automatic test_stall();
    logic [BL:0] obs, expv;
    logic [BL-1:0] held;
    int stall_bad;
    stall_bad = 0;
    do_reset();
    m_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 12; i++) send_word(BL'(i), 1'b0);
      end
      begin
        for (int t = 0; t < 200 && got_q.size() < 1; t++) @(posedge clk);
        #1 m_ready = 1'b0;
        held = m_data;
        for (int t = 0; t < 10; t++) begin
          @(negedge clk);
          if (m_valid !== 1'b1 || m_data !== held) stall_bad++;
        end
        n_checks++;
        if (stall_bad !== 0) begin n_fail++; $display("FAIL stall_hold: unstable cycles %0d, required 0", stall_bad); end
        n_checks++;
        if (held !== 8'd1) begin n_fail++; $display("FAIL stall_head: got %h, required 01", held); end
        n_checks++;
        if (s_ready !== 1'b0) begin n_fail++; $display("FAIL stall_sready: got %b, required 0", s_ready); end
        n_checks++;
        if (exp_q.size() !== 2 * DEPTH) begin n_fail++; $display("FAIL stall_accepted: got %0d, required %0d", exp_q.size(), 2 * DEPTH); end
        @(posedge clk);
        #1 m_ready = 1'b1;
      end
    join
    for (int t = 0; t < 500 && got_q.size() < 12; t++) @(posedge clk);
    n_checks++;
    if (got_q.size() !== 12) begin n_fail++; $display("FAIL stall_count: got %0d, required 12", got_q.size()); end
    for (int i = 0; i < 12; i++) begin
      obs = (i < got_q.size()) ? got_q[i] : 'x;
      expv = {1'(i % 4 == 3), BL'(i)};
      n_checks++;
      if (obs !== expv) begin n_fail++; $display("FAIL stall_word%0d: got %h, required %h", i, obs, expv); end
    end
  endtask

  task automatic test_random();
    logic wr_done;
    logic [BL:0] obs;
    wr_done = 1'b0;
    do_reset();
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          send_word(BL'($urandom), (i == 199) || ($urandom_range(0, 4) == 0));
        end
        wr_done = 1'b1;
      end
      begin
        for (int t = 0; t < 20000 && !wr_done; t++) begin
          @(posedge clk);
          #1 m_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    m_ready = 1'b1;
    for (int t = 0; t < 3000 && got_q.size() < exp_q.size(); t++) @(posedge clk);
    n_checks++;
    if (got_q.size() !== exp_q.size() || exp_q.size() !== 200) begin
      n_fail++; $display("FAIL rand_count: got %0d of %0d, required 200", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      obs = (i < got_q.size()) ? got_q[i] : 'x;
      n_checks++;
      if (obs !== exp_q[i]) begin n_fail++; $display("FAIL rand_word%0d: got %h, required %h", i, obs, exp_q[i]); end
    end
    n_checks++;
    if (we_viol !== 0) begin n_fail++; $display("FAIL rand_we_when_not_ready: got %0d, required 0", we_viol); end
    n_checks++;
    if (swap_viol !== 0) begin n_fail++; $display("FAIL rand_swap_in_flight: got %0d, required 0", swap_viol); end
    n_checks++;
    if (swaps !== frames_q.size()) begin n_fail++; $display("FAIL rand_swaps: got %0d, required %0d", swaps, frames_q.size()); end
  endtask

  task automatic test_reset_mid();
    logic [9:0] obs;
    logic mv_before;
    logic [BL:0] expv [3];
    logic [BL:0] got;
    expv = '{9'h050, 9'h051, 9'h152};
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) send_word(8'h40 + BL'(i), 1'b0);
    for (int t = 0; t < 100 && got_q.size() < 1; t++) @(posedge clk);
    #2;
    mv_before = m_valid;
    rst_n = 1'b0; s_valid = 1'b0;
    #1;
    n_checks++;
    if (mv_before !== 1'b1) begin n_fail++; $display("FAIL midreset_precond: m_valid got %b, required 1", mv_before); end
    obs = {s_ready, m_valid, m_last, pp_we1, pp_ping_pong, pp_we2, pp_addr1, pp_addr2};
    n_checks++;
    if (obs !== 10'b10_0000_0000) begin n_fail++; $display("FAIL midreset_outputs: got %b, required %b", obs, 10'b10_0000_0000); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send_word(8'h50, 1'b0);
    send_word(8'h51, 1'b0);
    send_word(8'h52, 1'b1);
    for (int t = 0; t < 200 && got_q.size() < 3; t++) @(posedge clk);
    n_checks++;
    if (got_q.size() !== 3) begin n_fail++; $display("FAIL midreset_count: got %0d, required 3", got_q.size()); end
    for (int i = 0; i < 3; i++) begin
      got = (i < got_q.size()) ? got_q[i] : 'x;
      n_checks++;
      if (got !== expv[i]) begin n_fail++; $display("FAIL midreset_word%0d: got %h, required %h", i, got, expv[i]); end
    end
  endtask

  task automatic test_single_word();
    logic [BL-1:0] d [6];
    logic [BL:0] obs;
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      d[i] = BL'($urandom);
      send_word(d[i], 1'b1);
    end
    for (int t = 0; t < 300 && got_q.size() < 6; t++) @(posedge clk);
    n_checks++;
    if (got_q.size() !== 6) begin n_fail++; $display("FAIL single_count: got %0d, required 6", got_q.size()); end
    for (int i = 0; i < 6; i++) begin
      obs = (i < got_q.size()) ? got_q[i] : 'x;
      n_checks++;
      if (obs !== {1'b1, d[i]}) begin n_fail++; $display("FAIL single_word%0d: got %h, required %h", i, obs, {1'b1, d[i]}); end
    end
    n_checks++;
    if (swaps !== 6) begin n_fail++; $display("FAIL single_swaps: got %0d, required 6", swaps); end
  endtask

  initial begin
    test_reset();
    test_steady();
    test_early_close();
    test_stall();
    test_random();
    test_reset_mid();
    test_single_word();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
